// File: rtl/apb_mst_pkg.sv
// Shared types for apb_master_ctrl: FSM states, registered response record, strobe-width helper.
// Optional wait-state timeout is enabled in the top by defining APB_MST_TIMEOUT_EN.
package apb_mst_pkg;

  localparam int MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Sized for the widest legal data bus; narrower builds use the low bits.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_master_ctrl.sv
// APB4 requester: accepts one valid/ready command at a time, runs a single APB transfer, returns a registered response.
// Define APB_MST_TIMEOUT_EN to abort transfers whose ACCESS phase sees PReady low for TO_CYC cycles.
module apb_master_ctrl
  import apb_mst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic                            PClk,
  input  logic                            PReset,
  input  logic                            ReqValid,
  output logic                            ReqReady,
  input  logic                            ReqWrite,
  input  logic [ADDR_W-1:0]               ReqAddr,
  input  logic [DATA_W-1:0]               ReqWData,
  input  logic [strb_width(DATA_W)-1:0]   ReqStrb,
  output logic                            RspValid,
  input  logic                            RspReady,
  output logic [DATA_W-1:0]               RspRData,
  output logic                            RspErr,
  output logic                            RspTimeout,
  output logic [ADDR_W-1:0]               PAddr,
  output logic                            PSel,
  output logic                            PEnable,
  output logic                            PWrite,
  output logic [DATA_W-1:0]               PWData,
  output logic [strb_width(DATA_W)-1:0]   PStrb,
  input  logic                            PReady,
  input  logic [DATA_W-1:0]               PRData,
  input  logic                            PSlvErr
);

  localparam int STRB_W = strb_width(DATA_W);

  apb_state_t            state;
  apb_rsp_t              rsp_q;
  logic [MAX_DATA_W-1:0] rdata_ext;

`ifdef APB_MST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
  logic [15:0] wait_cnt;
`endif

  assign rdata_ext  = MAX_DATA_W'(PRData);
  assign RspRData   = rsp_q.rdata[DATA_W-1:0];
  assign RspErr     = rsp_q.err;
  // Only the timeout path ever sets this bit, so without the macro it stays 0.
  assign RspTimeout = rsp_q.timeout;

  always_ff @(posedge PClk) begin
    if (PReset) begin
      state    <= IDLE;
      ReqReady <= 1'b0;
      RspValid <= 1'b0;
      rsp_q    <= '0;
      PAddr    <= '0;
      PSel     <= 1'b0;
      PEnable  <= 1'b0;
      PWrite   <= 1'b0;
      PWData   <= '0;
      PStrb    <= '0;
`ifdef APB_MST_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ReqReady <= 1'b1;
          if (ReqValid && ReqReady) begin
            ReqReady <= 1'b0;
            PAddr    <= ReqAddr;
            PWrite   <= ReqWrite;
            PWData   <= ReqWrite ? ReqWData : '0;
            PStrb    <= ReqWrite ? ReqStrb : STRB_W'(0);
            PSel     <= 1'b1;
            PEnable  <= 1'b0;
            state    <= SETUP;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        SETUP: begin
          PEnable <= 1'b1;
          state   <= ACCESS;
        end

        // PReady is checked first so it wins over a timeout landing on the same edge.
        ACCESS: begin
          if (PReady) begin
            PSel          <= 1'b0;
            PEnable       <= 1'b0;
            rsp_q.rdata   <= PWrite ? '0 : rdata_ext;
            rsp_q.err     <= PSlvErr;
            rsp_q.timeout <= 1'b0;
            RspValid      <= 1'b1;
            state         <= RESP;
          end
`ifdef APB_MST_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            PSel          <= 1'b0;
            PEnable       <= 1'b0;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            RspValid      <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            rsp_q    <= '0;
            ReqReady <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
